// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, 2-cycle latency, 1 op/cycle
module alu_arbiter #(
    parameter int         ARB_MODE     = 0,
    parameter int         STARVE_LIMIT = 4,
    parameter logic [3:0] OP_ADD       = 4'h0,
    parameter logic [3:0] OP_SUB       = 4'h1,
    parameter logic [3:0] OP_SL        = 4'h5,
    parameter logic [3:0] OP_CMP       = 4'h7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [3:0]  p0_op,
    input  logic [15:0] p0_a,
    input  logic [15:0] p0_b,
    input  logic        p0_flags_we,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [3:0]  p1_op,
    input  logic [15:0] p1_a,
    input  logic [15:0] p1_b,
    input  logic        p1_flags_we,
    output logic [3:0]  alux,
    output logic [15:0] arga,
    output logic [15:0] argb,
    input  logic [15:0] alu_result,
    input  logic        alu_sign,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_parity,
    output logic        rsp_valid,
    output logic        rsp_port,
    output logic [15:0] rsp_result,
    output logic        rsp_wb,
    output logic [3:0]  flags,
    output logic        busy
);
    logic       both, pick1, rr_pref, stage_we, stage_port, take, carry_def;
    logic [3:0] starve;
    // pick1 decides only contended cycles: RR turn or forced starvation grant
    assign both      = p0_valid && p1_valid;
    assign pick1     = (ARB_MODE == 0) ? rr_pref : (starve == 4'(STARVE_LIMIT));
    assign p0_ready  = !reset && !flush && p0_valid && !(p1_valid && pick1);
    assign p1_ready  = !reset && !flush && p1_valid && !(p0_valid && !pick1);
    assign take      = busy && !flush;
    assign carry_def = (alux == OP_ADD) || (alux == OP_SUB) || (alux == OP_SL);
    // Arbitration state, stage register (which directly drives the ALU), and response/flag capture
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_pref    <= 1'b0;
            starve     <= 4'd0;
            alux       <= 4'd0;
            arga       <= 16'd0;
            argb       <= 16'd0;
            stage_we   <= 1'b0;
            stage_port <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_port   <= 1'b0;
            rsp_result <= 16'd0;
            rsp_wb     <= 1'b0;
            flags      <= 4'd0;
        end else begin
            if (both && (p0_ready || p1_ready))
                rr_pref <= p0_ready;
            starve <= p1_ready ? 4'd0 :
                      (both && p0_ready && starve != 4'(STARVE_LIMIT)) ? starve + 4'd1 : starve;
            if (p0_ready || p1_ready)
                {alux, arga, argb, stage_we, stage_port} <= p1_ready ?
                    {p1_op, p1_a, p1_b, p1_flags_we, 1'b1} : {p0_op, p0_a, p0_b, p0_flags_we, 1'b0};
            busy      <= p0_ready || p1_ready;
            rsp_valid <= take;
            if (take) begin
                rsp_port   <= stage_port;
                rsp_result <= alu_result;
                rsp_wb     <= alux != OP_CMP;
                if (stage_we)
                    flags <= {alu_sign, carry_def ? alu_carry : flags[2], alu_zero, alu_parity};
            end
        end
    end
endmodule
